bram_read_arbiter: RTL and testbench
====================================

// Module: bram_read_arbiter
// PURPOSE
//  Sequences and shares the asymmetric instruction BRAM (write 32b / read 64b).
//  LOAD phase: host writes program words through this block. RUN phase: arbitrates
//  the single 64b read port among N regex engines and routes each response back to
//  its engine, tracking BRAM read latency.
// PARAMETERS
//  N_REQ        4   number of engine requesters (2..8)
//  R_ADDR_W     9   BRAM read address width (64b words)
//  R_DATA_W     64  BRAM read data width
//  W_ADDR_W     10  BRAM write address width (32b words)
//  W_DATA_W     32  BRAM write data width
//  RD_LAT       1   BRAM read latency in cycles (1..4)
// PORTS
//  clk          in   1               clock
//  rst          in   1               synchronous reset, active high
//  load_start   in   1               pulse: request entry to LOAD
//  load_done    in   1               pulse: leave LOAD, enter RUN
//  host_w_valid in   1               host write strobe
//  host_w_addr  in   W_ADDR_W        host write address
//  host_w_data  in   W_DATA_W        host write data
//  loading      out  1               1 while in LOAD or DRAIN
//  wr_err       out  1               sticky: host write while not in LOAD
//  req_valid    in   N_REQ           per-engine read request
//  req_addr     in   N_REQ*R_ADDR_W  per-engine address, engine i at [i*R_ADDR_W +: R_ADDR_W]
//  req_ready    out  N_REQ           one-hot grant; request accepted when valid&ready
//  rsp_valid    out  N_REQ           one-hot: rsp_data belongs to engine i
//  rsp_data     out  R_DATA_W        response data, shared bus
//  bram_r_valid out  1               to BRAM read enable
//  bram_r_addr  out  R_ADDR_W        to BRAM read address
//  bram_r_data  in   R_DATA_W        from BRAM read data
//  bram_w_valid out  1               to BRAM write enable
//  bram_w_addr  out  W_ADDR_W        to BRAM write address
//  bram_w_data  out  W_DATA_W        to BRAM write data
// BEHAVIOUR
//  Reset: state=LOAD, loading=1, wr_err=0, req_ready=0, rsp_valid=0, bram_r_valid=0,
//   bram_w_valid=0, RR pointer=0, latency pipe cleared (in-flight reads dropped).
//  FSM: LOAD --load_done--> RUN; RUN --load_start--> DRAIN;
//   DRAIN --pipe empty--> LOAD (same cycle as load_start if pipe already empty).
//   load_start and load_done together: load_start wins in RUN, load_done wins in LOAD.
//  LOAD: bram_w_* = host_w_* combinationally (no added latency); req_ready=0.
//  RUN/DRAIN: bram_w_valid=0; host_w_valid sets wr_err (cleared only by rst).
//  RUN arbitration: combinational round-robin over req_valid starting at pointer;
//   req_ready one-hot to winner, bram_r_valid=1, bram_r_addr=winner's addr.
//   Pointer <= winner+1 (mod N_REQ) on grant; unchanged when no request.
//   One grant per cycle, back-to-back grants allowed (full throughput).
//  DRAIN: no new grants; outstanding reads complete normally.
//  Response: grant one-hot shifted through RD_LAT-stage pipe; rsp_valid = pipe
//   output, rsp_data = bram_r_data passthrough. rsp_valid asserts exactly RD_LAT
//   cycles after the accepting cycle. No response backpressure: engines must sink.
//  Engine must hold req_valid/req_addr until req_ready.
// CONFIGURATION
//  BRAM_ARB_FIXED_PRIO_EN defined: fixed priority, lowest index wins, pointer unused.
//  Undefined (default): round-robin as above.
// TESTING
//  1 rst, host writes addr 0..3 = 0x11,0x22,0x33,0x44, load_done, eng0 reads addr 0
//    -> rsp_valid=0001 after RD_LAT, rsp_data=0x00000022_00000011.
//  2 RUN, all 4 engines valid continuously, RD_LAT=1 -> grants 0,1,2,3,0,...
//    one per cycle; each rsp_valid one-hot matches grant delayed 1 cycle.
//  3 host_w_valid=1 in RUN -> bram_w_valid=0, wr_err=1 and stays 1.
//  4 RD_LAT=3, grants in 2 consecutive cycles then load_start -> state DRAIN,
//    loading=1, both responses delivered, LOAD reached 2 cycles after last rsp.
//  5 rst asserted 1 cycle after a grant -> no rsp_valid ever for that read.
//  6 BRAM_ARB_FIXED_PRIO_EN, engines 1 and 3 valid -> engine 1 granted every cycle.

Source files
------------

// File: rtl/bram_read_arbiter.sv
// Instruction BRAM sequencer: host program load (LOAD), then round-robin sharing of the 64b
// read port among N_REQ engines (RUN). Define BRAM_ARB_FIXED_PRIO_EN for fixed lowest-index priority.
module bram_read_arbiter #(
    parameter int N_REQ    = 4,
    parameter int R_ADDR_W = 9,
    parameter int R_DATA_W = 64,
    parameter int W_ADDR_W = 10,
    parameter int W_DATA_W = 32,
    parameter int RD_LAT   = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      load_start,
    input  logic                      load_done,
    input  logic                      host_w_valid,
    input  logic [W_ADDR_W-1:0]       host_w_addr,
    input  logic [W_DATA_W-1:0]       host_w_data,
    output logic                      loading,
    output logic                      wr_err,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ*R_ADDR_W-1:0] req_addr,
    output logic [N_REQ-1:0]          req_ready,
    output logic [N_REQ-1:0]          rsp_valid,
    output logic [R_DATA_W-1:0]       rsp_data,
    output logic                      bram_r_valid,
    output logic [R_ADDR_W-1:0]       bram_r_addr,
    input  logic [R_DATA_W-1:0]       bram_r_data,
    output logic                      bram_w_valid,
    output logic [W_ADDR_W-1:0]       bram_w_addr,
    output logic [W_DATA_W-1:0]       bram_w_data,
    output logic [1:0]                dbg_state
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    state_e             state_q;
    logic               loading_q;
    logic               wr_err_q;
    logic [PTR_W-1:0]   ptr_q;
    logic [PTR_W-1:0]   ptr_d;
    logic [N_REQ-1:0]   pipe_q [RD_LAT];
    logic               pipe_empty;

    logic [N_REQ-1:0]   grant_oh;
    logic [PTR_W-1:0]   grant_idx;
    logic               grant_any;
    logic [R_ADDR_W-1:0] grant_addr;
`ifndef BRAM_ARB_FIXED_PRIO_EN
    logic [PTR_W-1:0]   rr_idx;
`endif

    // Handshake: a read is accepted in the cycle req_valid[i] & req_ready[i]; the engine
    // holds valid/addr until then, and must sink rsp_valid[i] exactly RD_LAT cycles later.
    always_comb begin
        grant_oh  = '0;
        grant_idx = '0;
        grant_any = 1'b0;
`ifndef BRAM_ARB_FIXED_PRIO_EN
        rr_idx    = '0;
`endif
        if (state_q == ST_RUN) begin
            // Scanning downwards lets the last hit (closest to the start point) win.
            for (int k = N_REQ - 1; k >= 0; k--) begin
`ifdef BRAM_ARB_FIXED_PRIO_EN
                if (req_valid[k]) begin
                    grant_idx = PTR_W'(k);
                    grant_any = 1'b1;
                end
`else
                rr_idx = PTR_W'((int'(ptr_q) + k) % N_REQ);
                if (req_valid[rr_idx]) begin
                    grant_idx = rr_idx;
                    grant_any = 1'b1;
                end
`endif
            end
            if (grant_any) begin
                grant_oh[grant_idx] = 1'b1;
            end
        end
    end

    always_comb begin
        grant_addr = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (grant_oh[k]) begin
                grant_addr = req_addr[k*R_ADDR_W +: R_ADDR_W];
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (grant_any) begin
            ptr_d = (grant_idx == PTR_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    always_comb begin
        pipe_empty = 1'b1;
        for (int k = 0; k < RD_LAT; k++) begin
            if (pipe_q[k] != '0) begin
                pipe_empty = 1'b0;
            end
        end
    end

    // Grant tracking pipe: each stage mirrors one cycle of BRAM read latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < RD_LAT; k++) begin
                pipe_q[k] <= '0;
            end
        end else begin
            pipe_q[0] <= grant_oh;
            for (int k = 1; k < RD_LAT; k++) begin
                pipe_q[k] <= pipe_q[k-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_LOAD;
            loading_q <= 1'b1;
            wr_err_q  <= 1'b0;
            ptr_q     <= '0;
        end else begin
            if (host_w_valid && (state_q != ST_LOAD)) begin
                wr_err_q <= 1'b1;
            end
            ptr_q <= ptr_d;
            case (state_q)
                ST_LOAD: begin
                    if (load_done) begin
                        state_q   <= ST_RUN;
                        loading_q <= 1'b0;
                    end
                end
                ST_RUN: begin
                    // A grant issued in this same cycle still has to drain.
                    if (load_start) begin
                        state_q   <= (pipe_empty && !grant_any) ? ST_LOAD : ST_DRAIN;
                        loading_q <= 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (pipe_empty) begin
                        state_q <= ST_LOAD;
                    end
                end
                default: begin
                    state_q   <= ST_LOAD;
                    loading_q <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready    = grant_oh;
    assign bram_r_valid = grant_any;
    assign bram_r_addr  = grant_addr;
    assign rsp_valid    = pipe_q[RD_LAT-1];
    assign rsp_data     = bram_r_data;

    assign bram_w_valid = host_w_valid && (state_q == ST_LOAD);
    assign bram_w_addr  = host_w_addr;
    assign bram_w_data  = host_w_data;

    assign loading   = loading_q;
    assign wr_err    = wr_err_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_bram_read_arbiter.sv
// Bench for bram_read_arbiter: one instance at RD_LAT=1 and one at RD_LAT=3 share the load
// controls; each has its own BRAM model and response scoreboard.
module tb_bram_read_arbiter;

    localparam int N  = 4;
    localparam int AW = 9;
    localparam int SB_W = 100;  // {due_cycle[31:0], engine_onehot[3:0], data[63:0]}

    logic clk;
    logic rst;
    logic load_start, load_done;
    logic host_w_valid;
    logic [9:0]  host_w_addr;
    logic [31:0] host_w_data;

    logic a_loading, a_wr_err, a_bram_r_valid, a_bram_w_valid;
    logic [N-1:0] a_req_valid, a_req_ready, a_rsp_valid;
    logic [N*AW-1:0] a_req_addr;
    logic [63:0] a_rsp_data, a_bram_r_data;
    logic [AW-1:0] a_bram_r_addr;
    logic [9:0] a_bram_w_addr;
    logic [31:0] a_bram_w_data;
    logic [1:0] a_dbg_state;

    logic b_loading, b_wr_err, b_bram_r_valid, b_bram_w_valid;
    logic [N-1:0] b_req_valid, b_req_ready, b_rsp_valid;
    logic [N*AW-1:0] b_req_addr;
    logic [63:0] b_rsp_data, b_bram_r_data;
    logic [AW-1:0] b_bram_r_addr;
    logic [9:0] b_bram_w_addr;
    logic [31:0] b_bram_w_data;
    logic [1:0] b_dbg_state;

    bram_read_arbiter #(.N_REQ(N), .RD_LAT(1)) u_dut_a (
        .clk(clk), .rst(rst), .load_start(load_start), .load_done(load_done),
        .host_w_valid(host_w_valid), .host_w_addr(host_w_addr), .host_w_data(host_w_data),
        .loading(a_loading), .wr_err(a_wr_err),
        .req_valid(a_req_valid), .req_addr(a_req_addr), .req_ready(a_req_ready),
        .rsp_valid(a_rsp_valid), .rsp_data(a_rsp_data),
        .bram_r_valid(a_bram_r_valid), .bram_r_addr(a_bram_r_addr), .bram_r_data(a_bram_r_data),
        .bram_w_valid(a_bram_w_valid), .bram_w_addr(a_bram_w_addr), .bram_w_data(a_bram_w_data),
        .dbg_state(a_dbg_state)
    );

    bram_read_arbiter #(.N_REQ(N), .RD_LAT(3)) u_dut_b (
        .clk(clk), .rst(rst), .load_start(load_start), .load_done(load_done),
        .host_w_valid(host_w_valid), .host_w_addr(host_w_addr), .host_w_data(host_w_data),
        .loading(b_loading), .wr_err(b_wr_err),
        .req_valid(b_req_valid), .req_addr(b_req_addr), .req_ready(b_req_ready),
        .rsp_valid(b_rsp_valid), .rsp_data(b_rsp_data),
        .bram_r_valid(b_bram_r_valid), .bram_r_addr(b_bram_r_addr), .bram_r_data(b_bram_r_data),
        .bram_w_valid(b_bram_w_valid), .bram_w_addr(b_bram_w_addr), .bram_w_data(b_bram_w_data),
        .dbg_state(b_dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // ---------------- BRAM models ----------------
    logic [31:0] a_mem [1024];
    logic [31:0] b_mem [1024];
    logic [31:0] shadow [1024];
    logic [63:0] a_rd;
    logic [63:0] b_rd [3];

    always @(posedge clk) begin
        if (a_bram_w_valid) a_mem[a_bram_w_addr] <= a_bram_w_data;
        if (b_bram_w_valid) b_mem[b_bram_w_addr] <= b_bram_w_data;
        a_rd    <= {a_mem[{a_bram_r_addr, 1'b1}], a_mem[{a_bram_r_addr, 1'b0}]};
        b_rd[0] <= {b_mem[{b_bram_r_addr, 1'b1}], b_mem[{b_bram_r_addr, 1'b0}]};
        b_rd[1] <= b_rd[0];
        b_rd[2] <= b_rd[1];
    end
    assign a_bram_r_data = a_rd;
    assign b_bram_r_data = b_rd[2];

    // ---------------- checking ----------------
    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] exp_word(input logic [AW-1:0] ad);
        return {shadow[{ad, 1'b1}], shadow[{ad, 1'b0}]};
    endfunction

    // Reference arbitration: who should win among v, given the bench's pointer p.
    function automatic logic [N-1:0] exp_grant(input logic [N-1:0] v, input int p);
        logic [N-1:0] r;
        r = '0;
`ifdef BRAM_ARB_FIXED_PRIO_EN
        for (int k = N - 1; k >= 0; k--) begin
            if (v[k]) begin
                r = '0;
                r[k] = 1'b1;
            end
        end
`else
        for (int k = N - 1; k >= 0; k--) begin
            if (v[(p + k) % N]) begin
                r = '0;
                r[(p + k) % N] = 1'b1;
            end
        end
`endif
        return r;
    endfunction

    // ---------------- scoreboards ----------------
    logic [SB_W-1:0] a_exp_q[$];
    logic [SB_W-1:0] b_exp_q[$];
    logic [SB_W-1:0] a_e, b_e;
    logic [N-1:0] a_hs, b_hs;
    logic [AW-1:0] a_ad, b_ad;

    always @(negedge clk) begin
        if (rst) begin
            a_exp_q.delete();
        end else begin
            if (a_rsp_valid != '0) begin
                if (a_exp_q.size() == 0) begin
                    check_eq("a_rsp_unexpected", a_rsp_valid, 0);
                end else begin
                    a_e = a_exp_q.pop_front();
                    check_eq("a_rsp_eng", a_rsp_valid, a_e[67:64]);
                    check_eq("a_rsp_data", a_rsp_data, a_e[63:0]);
                    check_eq("a_rsp_lat", cyc, a_e[99:68]);
                end
            end else if (a_exp_q.size() != 0 && a_exp_q[0][99:68] == cyc) begin
                check_eq("a_rsp_missing", a_rsp_valid, a_exp_q[0][67:64]);
            end
            a_hs = a_req_valid & a_req_ready;
            if (a_hs != '0) begin
                check_eq("a_grant_onehot", $onehot(a_hs), 1);
                a_ad = '0;
                for (int k = 0; k < N; k++) if (a_hs[k]) a_ad = a_req_addr[k*AW +: AW];
                a_exp_q.push_back({32'(cyc + 1), a_hs, exp_word(a_ad)});
            end
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            b_exp_q.delete();
        end else begin
            if (b_rsp_valid != '0) begin
                if (b_exp_q.size() == 0) begin
                    check_eq("b_rsp_unexpected", b_rsp_valid, 0);
                end else begin
                    b_e = b_exp_q.pop_front();
                    check_eq("b_rsp_eng", b_rsp_valid, b_e[67:64]);
                    check_eq("b_rsp_data", b_rsp_data, b_e[63:0]);
                    check_eq("b_rsp_lat", cyc, b_e[99:68]);
                end
            end else if (b_exp_q.size() != 0 && b_exp_q[0][99:68] == cyc) begin
                check_eq("b_rsp_missing", b_rsp_valid, b_exp_q[0][67:64]);
            end
            b_hs = b_req_valid & b_req_ready;
            if (b_hs != '0) begin
                check_eq("b_grant_onehot", $onehot(b_hs), 1);
                b_ad = '0;
                for (int k = 0; k < N; k++) if (b_hs[k]) b_ad = b_req_addr[k*AW +: AW];
                b_exp_q.push_back({32'(cyc + 3), b_hs, exp_word(b_ad)});
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input logic [9:0] ad, input logic [31:0] d);
        host_w_valid = 1'b1;
        host_w_addr  = ad;
        host_w_data  = d;
        shadow[ad]   = d;
        @(negedge clk);
        check_eq("w_valid", a_bram_w_valid, 1);
        check_eq("w_addr", a_bram_w_addr, ad);
        check_eq("w_data", a_bram_w_data, d);
        check_eq("b_w_valid", b_bram_w_valid, 1);
        tick();
    endtask

    // Runs all four request lines of DUT A against the reference arbiter for n cycles.
    int tb_ptr = 0;
    task automatic run_a_grants(input logic [N-1:0] v, input int n, input string tag);
        logic [N-1:0] eg;
        a_req_valid = v;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            eg = exp_grant(a_req_valid, tb_ptr);
            check_eq(tag, a_req_ready, eg);
            for (int k = 0; k < N; k++) begin
                if (eg[k]) tb_ptr = (k + 1) % N;
            end
            tick();
            for (int k = 0; k < N; k++) begin
                if (eg[k]) a_req_addr[k*AW +: AW] = AW'($urandom_range(0, 7));
            end
        end
        a_req_valid = '0;
    endtask

    // ---------------- stimulus ----------------
    int last_rsp, load_cyc, found;

    initial begin
        rst = 1'b1;
        load_start = 1'b0;
        load_done = 1'b0;
        host_w_valid = 1'b0;
        host_w_addr = '0;
        host_w_data = '0;
        a_req_valid = '0;
        a_req_addr = '0;
        b_req_valid = '0;
        b_req_addr = '0;
        repeat (3) tick();

        @(negedge clk);
        check_eq("rst_loading", a_loading, 1);
        check_eq("rst_wr_err", a_wr_err, 0);
        check_eq("rst_state", a_dbg_state, 0);
        check_eq("rst_rsp_valid", a_rsp_valid, 0);
        check_eq("rst_bram_r_valid", a_bram_r_valid, 0);
        check_eq("rst_bram_w_valid", a_bram_w_valid, 0);
        check_eq("rst_b_state", b_dbg_state, 0);
        tick();
        rst = 1'b0;

        // Requests during LOAD are never granted.
        a_req_valid = '1;
        @(negedge clk);
        check_eq("load_no_ready", a_req_ready, 0);
        check_eq("load_no_rd", a_bram_r_valid, 0);
        tick();
        a_req_valid = '0;

        for (int w = 0; w < 16; w++) begin
            write_word(10'(w), (w < 4) ? 32'(w + 1) * 32'h11 : $urandom);
        end
        host_w_valid = 1'b0;

        load_done = 1'b1;
        @(negedge clk);
        check_eq("ld_still_load", a_dbg_state, 0);
        tick();
        load_done = 1'b0;
        @(negedge clk);
        check_eq("run_state", a_dbg_state, 1);
        check_eq("run_loading", a_loading, 0);
        check_eq("run_b_state", b_dbg_state, 1);

        // Engine 0 reads word 0.
        tick();
        a_req_valid = 4'b0001;
        a_req_addr[0 +: AW] = '0;
        @(negedge clk);
        check_eq("t1_ready", a_req_ready, exp_grant(4'b0001, tb_ptr));
        check_eq("t1_r_valid", a_bram_r_valid, 1);
        check_eq("t1_r_addr", a_bram_r_addr, 0);
        tb_ptr = 1;
        tick();
        a_req_valid = '0;
        @(negedge clk);
        check_eq("t1_rsp_valid", a_rsp_valid, 4'b0001);
        check_eq("t1_rsp_data", a_rsp_data, 64'h00000022_00000011);
        tick();

        // All engines requesting continuously.
        for (int k = 0; k < N; k++) a_req_addr[k*AW +: AW] = AW'($urandom_range(0, 7));
        run_a_grants(4'b1111, 10, "t2_grant");
        // Engines 1 and 3 only.
        run_a_grants(4'b1010, 6, "t6_grant");
        tick();

        // Host write while in RUN.
        host_w_valid = 1'b1;
        host_w_addr = 10'd5;
        host_w_data = 32'hBAD0_0005;
        @(negedge clk);
        check_eq("t3_no_bram_w", a_bram_w_valid, 0);
        check_eq("t3_no_bram_w_b", b_bram_w_valid, 0);
        tick();
        host_w_valid = 1'b0;
        @(negedge clk);
        check_eq("t3_wr_err", a_wr_err, 1);
        check_eq("t3_wr_err_b", b_wr_err, 1);
        repeat (3) tick();
        @(negedge clk);
        check_eq("t3_wr_err_sticky", a_wr_err, 1);
        // Word 5 must still hold the loaded value.
        tick();
        a_req_addr[0 +: AW] = 9'd2;
        run_a_grants(4'b0001, 1, "t3_readback_grant");
        repeat (2) tick();

        // Two grants on the RD_LAT=3 instance, then load_start.
        b_req_valid = 4'b0001;
        b_req_addr[0 +: AW] = 9'd1;
        @(negedge clk);
        check_eq("t4_grant0", b_req_ready, 4'b0001);
        tick();
        b_req_valid = 4'b0010;
        b_req_addr[AW +: AW] = 9'd3;
        @(negedge clk);
        check_eq("t4_grant1", b_req_ready, 4'b0010);
        tick();
        b_req_valid = '0;
        load_start = 1'b1;
        @(negedge clk);
        check_eq("t4_still_run", b_dbg_state, 1);
        tick();
        load_start = 1'b0;
        b_req_valid = 4'b0100;
        b_req_addr[2*AW +: AW] = 9'd0;
        @(negedge clk);
        check_eq("t4_drain", b_dbg_state, 2);
        check_eq("t4_drain_loading", b_loading, 1);
        check_eq("t4_drain_no_grant", b_req_ready, 0);
        check_eq("t4_a_direct_load", a_dbg_state, 0);
        check_eq("t4_a_loading", a_loading, 1);
        b_req_valid = '0;
        last_rsp = -1;
        load_cyc = -1;
        found = 0;
        for (int k = 0; k < 20 && found == 0; k++) begin
            if (b_rsp_valid != '0) last_rsp = cyc;
            if (b_dbg_state == 2'd0) begin
                load_cyc = cyc;
                found = 1;
            end else begin
                @(negedge clk);
            end
        end
        check_eq("t4_load_reached", found, 1);
        check_eq("t4_load_after_rsp", load_cyc - last_rsp, 2);
        check_eq("t4_b_sb_empty", b_exp_q.size(), 0);

        // Reset one cycle after a grant drops the read.
        tick();
        load_done = 1'b1;
        tick();
        load_done = 1'b0;
        b_req_valid = 4'b0100;
        b_req_addr[2*AW +: AW] = 9'd5;
        @(negedge clk);
        check_eq("t5_grant", b_req_ready, 4'b0100);
        tick();
        b_req_valid = '0;
        rst = 1'b1;
        @(negedge clk);
        check_eq("t5_rst_no_rsp", b_rsp_valid, 0);
        tick();
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check_eq("t5_dropped", b_rsp_valid, 0);
            tick();
        end
        @(negedge clk);
        check_eq("t5_state", b_dbg_state, 0);
        check_eq("t5_loading", b_loading, 1);
        check_eq("t5_wr_err_cleared", b_wr_err, 0);
        check_eq("t5_wr_err_cleared_a", a_wr_err, 0);
        check_eq("end_a_sb_empty", a_exp_q.size(), 0);
        check_eq("end_b_sb_empty", b_exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
